adc_tape_slicer: RTL

- Converts the raw mono ADC sample stream (ltc2308 dout / dout_sync toggle) into a clean 1-bit cassette signal for the mc10 `cin` input, the tape-audio mux and the tape overlay.
- Runs a 2^DEPTH_LOG2-sample running average held in an inferred RAM ring buffer, acting as a ~100 Hz high-pass reference.
- Slices each sample against that average with a hysteresis window.
- Replaces the inline ADC averaging logic in the top level with a pipelined, RAM-based, correctly primed block.

---
 rtl/adc_tape_slicer_if.sv | 21 ++
 rtl/adc_tape_slicer.sv | 105 ++++++++++
 2 files changed

// File: rtl/adc_tape_slicer_if.sv
// Sample stream in, sliced cassette bit and status out; adc_sync toggles once per sample.
// The slicer core is the slave; the ADC front end or bench is the master.
interface adc_tape_slicer_if;
  logic [11:0] adc_data;
  logic        adc_sync;
  logic        bit_out;
  logic [11:0] avg_out;
  logic        sample_stb;
  logic        primed;
  logic        overrun;

  modport master (
    output adc_data, adc_sync,
    input  bit_out, avg_out, sample_stb, primed, overrun
  );

  modport slave (
    input  adc_data, adc_sync,
    output bit_out, avg_out, sample_stb, primed, overrun
  );
endinterface

// File: rtl/adc_tape_slicer.sv
// Running-average hysteresis slicer: outputs update 3 cycles after a sample event, one sample per 4 cycles.
// No backpressure: events arriving while busy are dropped and flagged on the sticky overrun bit.
module adc_tape_slicer #(
  parameter int DEPTH_LOG2 = 9,
  parameter int THRESH     = 100,
  parameter bit INVERT     = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  adc_tape_slicer_if.slave   bus
);

  localparam int N  = DEPTH_LOG2;
  localparam int TW = 12 + N;
  localparam logic signed [13:0] TH = 14'(THRESH);

  typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;

  state_t        state;
  logic          sync_d;
  logic          ev;
  logic [N-1:0]  wr_ptr;
  logic [N:0]    fill;
  logic [TW-1:0] total;
  logic [11:0]   smp;
  logic [11:0]   ram_q;
  logic [11:0]   mem [2**N];

  logic [TW-1:0]      old_w;
  logic [TW-1:0]      total_n;
  logic [N:0]         fill_n;
  logic               full_n;
  logic [11:0]        avg_n;
  logic signed [13:0] s_smp;
  logic signed [13:0] lo;
  logic signed [13:0] hi;

  assign ev = bus.adc_sync ^ sync_d;

  // Oldest entry only leaves the sum once the window really holds it.
  always_comb begin
    old_w   = fill[N] ? TW'(ram_q) : '0;
    total_n = total - old_w + TW'(smp);
    fill_n  = fill[N] ? fill : fill + 1'b1;
    full_n  = fill_n[N];
    avg_n   = total_n[TW-1:N];
    s_smp   = $signed({2'b00, smp});
    lo      = $signed({2'b00, avg_n}) - TH;
    hi      = $signed({2'b00, avg_n}) + TH;
  end

  always_ff @(posedge clk) begin
    if (state == S1)
      ram_q <= mem[wr_ptr];
    if (state == S2 && !reset)
      mem[wr_ptr] <= smp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      sync_d         <= bus.adc_sync;
      wr_ptr         <= '0;
      fill           <= '0;
      total          <= '0;
      smp            <= '0;
      bus.avg_out    <= '0;
      bus.bit_out    <= 1'b0;
      bus.sample_stb <= 1'b0;
      bus.primed     <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      sync_d         <= bus.adc_sync;
      bus.sample_stb <= 1'b0;
      if (ev && state != IDLE)
        bus.overrun <= 1'b1;
      case (state)
        IDLE: if (ev) state <= S1;
        S1: begin
          smp   <= bus.adc_data;
          state <= S2;
        end
        S2: begin
          total          <= total_n;
          wr_ptr         <= wr_ptr + 1'b1;
          fill           <= fill_n;
          bus.avg_out    <= avg_n;
          bus.primed     <= full_n;
          bus.sample_stb <= 1'b1;
          // Strict compares; a negative lo or hi above full scale simply never fires.
          if (full_n) begin
            if (s_smp < lo)
              bus.bit_out <= INVERT;
            else if (s_smp > hi)
              bus.bit_out <= ~INVERT;
          end
          state <= S3;
        end
        S3:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
